// File: rtl/sender_pattern_gen_if.sv
// Bus between the test-pattern source and its consumer.
// Handshake: "ready" is the valid flag for word_out. With HOLD_MODE=0 it is
// a one-cycle strobe and ack is unused. With HOLD_MODE=1, ready and word_out
// stay stable until ack=1 is sampled while ready=1, and ready drops on that
// edge. A request (falling edge of ready_in) seen while ready=1 is dropped
// and flagged on overrun.
interface sender_pattern_gen_if #(
  parameter int W = 16
);
  logic         en;
  logic         ready_in;
  logic [1:0]   mode;
  logic         clear;
  logic         ack;
  logic [W-1:0] word_out;
  logic         ready;
  logic         overrun;
  logic [15:0]  word_cnt;

  modport master (
    input  en, ready_in, mode, clear, ack,
    output word_out, ready, overrun, word_cnt
  );

  modport slave (
    output en, ready_in, mode, clear, ack,
    input  word_out, ready, overrun, word_cnt
  );
endinterface

// File: rtl/sender_pattern_gen.sv
// Parametrised test-pattern source for the logic analyser sender path.
// Each falling edge of the asynchronous ready_in emits one BYTES-wide word
// built from a run-time selectable pattern (counter, walking one, LFSR,
// alternating 0xAA/0x55). Byte 0 is placed in the most significant byte.
module sender_pattern_gen #(
  parameter int         BYTES     = 2,
  parameter int         HOLD_MODE = 0,
  parameter logic [7:0] LFSR_SEED = 8'h01
) (
  input logic                  rdclk,
  input logic                  reset,
  sender_pattern_gen_if.master bus
);

  localparam int W   = 8 * BYTES;
  localparam int WPW = $clog2(W);
  // An all-zero LFSR would lock up, so a zero seed falls back to 1.
  localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  // One step of the 8-bit maximal-length LFSR (period 255).
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  logic [1:0]     sreg,      sreg_n;
  logic [7:0]     seq,       seq_n;
  logic [WPW-1:0] walk_pos,  walk_n;
  logic [7:0]     lfsr,      lfsr_n;
  logic [W-1:0]   word_q,    word_n;
  logic           ready_q,   ready_n;
  logic           overrun_q, overrun_n;
  logic [15:0]    cnt_q,     cnt_n;

  logic           trig;
  logic [W-1:0]   pattern;
  logic [7:0]     pat_byte;
  logic [7:0]     lfsr_adv;
  logic [WPW-1:0] walk_wrap;

  // Falling edge of the synchronised request.
  assign trig = sreg[1] & ~sreg[0];

  assign walk_wrap = (walk_pos == WPW'(W - 1)) ? '0 : walk_pos + 1'b1;

  // Candidate output word from the current pattern state, plus the LFSR
  // value after BYTES steps (one step per byte of the word).
  always_comb begin : pattern_calc
    pattern  = '0;
    pat_byte = 8'h00;
    lfsr_adv = lfsr;
    for (int k = 0; k < BYTES; k++) begin
      unique case (bus.mode)
        2'd0:    pat_byte = seq * 8'(BYTES) + 8'(k);
        2'd2:    pat_byte = lfsr_adv;
        2'd3:    pat_byte = seq[0] ? 8'h55 : 8'hAA;
        default: pat_byte = 8'h00;
      endcase
      pattern[W-1-8*k -: 8] = pat_byte;
      lfsr_adv = lfsr_step(lfsr_adv);
    end
    if (bus.mode == 2'd1) begin
      pattern = {1'b1, {(W-1){1'b0}}} >> walk_pos;
    end
  end

  // Next-state: synchroniser shift, clear, release, acceptance and overrun.
  always_comb begin : next_state
    sreg_n    = sreg;
    seq_n     = seq;
    walk_n    = walk_pos;
    lfsr_n    = lfsr;
    word_n    = word_q;
    ready_n   = ready_q;
    overrun_n = overrun_q;
    cnt_n     = cnt_q;
    if (bus.en) begin
      sreg_n = {sreg[0], bus.ready_in};
      if (bus.clear) begin
        // Restart the pattern; any request seen on this edge is discarded.
        seq_n     = 8'h00;
        walk_n    = '0;
        lfsr_n    = SEED;
        cnt_n     = 16'h0000;
        overrun_n = 1'b0;
        ready_n   = 1'b0;
      end else begin
        if (ready_q) begin
          if (HOLD_MODE == 0) begin
            ready_n = 1'b0;
          end else if (bus.ack) begin
            ready_n = 1'b0;
          end
        end
        if (trig) begin
          // Acceptance looks at ready before this edge's release.
          if (ready_q) begin
            overrun_n = 1'b1;
          end else begin
            word_n  = pattern;
            ready_n = 1'b1;
            cnt_n   = cnt_q + 16'd1;
            seq_n   = seq + 8'd1;
            walk_n  = walk_wrap;
            lfsr_n  = lfsr_adv;
          end
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge rdclk) begin
    if (reset) begin
      sreg      <= 2'b00;
      seq       <= 8'h00;
      walk_pos  <= '0;
      lfsr      <= SEED;
      word_q    <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      cnt_q     <= 16'h0000;
    end else begin
      sreg      <= sreg_n;
      seq       <= seq_n;
      walk_pos  <= walk_n;
      lfsr      <= lfsr_n;
      word_q    <= word_n;
      ready_q   <= ready_n;
      overrun_q <= overrun_n;
      cnt_q     <= cnt_n;
    end
  end

  assign bus.word_out = word_q;
  assign bus.ready    = ready_q;
  assign bus.overrun  = overrun_q;
  assign bus.word_cnt = cnt_q;

endmodule

// File: tb/tb_sender_pattern_gen.sv
// Bench for sender_pattern_gen: a strobe-mode 2-byte instance and a
// hold-mode 1-byte instance (zero seed) share the request stimulus.
module tb_sender_pattern_gen;

  // ---------------- clock / reset ----------------
  logic rdclk = 1'b0;
  always #5 rdclk = ~rdclk;

  logic       reset;
  logic       en;
  logic       ready_in;
  logic [1:0] mode;
  logic       clear;
  logic       ack;

  sender_pattern_gen_if #(.W(16)) bus_a();
  sender_pattern_gen_if #(.W(8))  bus_b();

  assign bus_a.en = en;  assign bus_a.ready_in = ready_in;  assign bus_a.mode = mode;
  assign bus_a.clear = clear;  assign bus_a.ack = ack;
  assign bus_b.en = en;  assign bus_b.ready_in = ready_in;  assign bus_b.mode = mode;
  assign bus_b.clear = clear;  assign bus_b.ack = ack;

  sender_pattern_gen #(.BYTES(2), .HOLD_MODE(0), .LFSR_SEED(8'h01)) u_a (
    .rdclk(rdclk), .reset(reset), .bus(bus_a)
  );
  sender_pattern_gen #(.BYTES(1), .HOLD_MODE(1), .LFSR_SEED(8'h00)) u_b (
    .rdclk(rdclk), .reset(reset), .bus(bus_b)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [79:0] exp_a_q[$];   // {word_cnt, word}
  logic [79:0] exp_b_q[$];

  // Reference model: pattern indices kept as plain integers.
  logic [7:0] lfsr_tab[255];
  int m_seq[2], m_walk[2], m_lp[2], m_cnt[2];
  int b_pend, b_ov;

  bit         cap_lfsr = 1'b0;
  logic [7:0] seen_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic logic [63:0] model_word(input int d, input int m);
    logic [63:0] w;
    logic [7:0]  b;
    int nb;
    nb = nbytes(d);
    w  = '0;
    if (m == 1) return 64'd1 << (8 * nb - 1 - m_walk[d]);
    for (int k = 0; k < nb; k++) begin
      if (m == 0)      b = 8'((m_seq[d] * nb + k) % 256);
      else if (m == 2) b = lfsr_tab[(m_lp[d] + k) % 255];
      else             b = (m_seq[d] % 2 == 1) ? 8'h55 : 8'hAA;
      w[8*nb-1-8*k -: 8] = b;
    end
    return w;
  endfunction

  task automatic model_accept(input int d);
    logic [63:0] w;
    w = model_word(d, int'(mode));
    m_cnt[d]  = (m_cnt[d] + 1) % 65536;
    if (d == 0) exp_a_q.push_back({16'(m_cnt[d]), w});
    else        exp_b_q.push_back({16'(m_cnt[d]), w});
    m_seq[d]  = (m_seq[d] + 1) % 256;
    m_walk[d] = (m_walk[d] + 1) % (8 * nbytes(d));
    m_lp[d]   = (m_lp[d] + nbytes(d)) % 255;
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_seq[d] = 0; m_walk[d] = 0; m_lp[d] = 0; m_cnt[d] = 0;
    end
    b_pend = 0;
    b_ov   = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic ack_pulse();
    ack = 1'b1;
    @(negedge rdclk);
    ack = 1'b0;
    b_pend = 0;
    chk("b_ready_after_ack", 64'(bus_b.ready), 64'd0);
  endtask

  task automatic do_req(input bit with_ack);
    ready_in = 1'b1;
    repeat (3) @(negedge rdclk);
    ready_in = 1'b0;
    model_accept(0);
    if (b_pend != 0) b_ov = 1;
    else begin
      model_accept(1);
      b_pend = 1;
    end
    repeat (4) @(negedge rdclk);
    if (with_ack) ack_pulse();
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(negedge rdclk);
    clear = 1'b0;
    model_clear();
    chk("clr_a_ready", 64'(bus_a.ready), 64'd0);
    chk("clr_b_ready", 64'(bus_b.ready), 64'd0);
    chk("clr_b_overrun", 64'(bus_b.overrun), 64'd0);
    chk("clr_a_cnt", 64'(bus_a.word_cnt), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_word"}, 64'(bus_a.word_out), 64'd0);
    chk({tag, "_a_ready"}, 64'(bus_a.ready), 64'd0);
    chk({tag, "_a_ovr"}, 64'(bus_a.overrun), 64'd0);
    chk({tag, "_a_cnt"}, 64'(bus_a.word_cnt), 64'd0);
    chk({tag, "_b_word"}, 64'(bus_b.word_out), 64'd0);
    chk({tag, "_b_ready"}, 64'(bus_b.ready), 64'd0);
    chk({tag, "_b_ovr"}, 64'(bus_b.overrun), 64'd0);
    chk({tag, "_b_cnt"}, 64'(bus_b.word_cnt), 64'd0);
  endtask

  // ---------------- monitors ----------------
  logic        prev_a = 1'b0;
  logic        prev_b = 1'b0;
  logic [7:0]  held_b = 8'h00;
  logic [79:0] e_a, e_b;

  always @(negedge rdclk) begin : mon_a
    if (prev_a) chk("a_ready_one_cycle", 64'(bus_a.ready), 64'd0);
    else if (bus_a.ready) begin
      if (exp_a_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_word: got %0h expected none", bus_a.word_out);
      end else begin
        e_a = exp_a_q.pop_front();
        chk("a_word", 64'(bus_a.word_out), 64'(e_a[15:0]));
        chk("a_cnt", 64'(bus_a.word_cnt), 64'(e_a[79:64]));
      end
    end
    prev_a = bus_a.ready;
  end

  always @(negedge rdclk) begin : mon_b
    if (bus_b.ready && prev_b) chk("b_hold_stable", 64'(bus_b.word_out), 64'(held_b));
    else if (bus_b.ready) begin
      if (exp_b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_word: got %0h expected none", bus_b.word_out);
      end else begin
        e_b = exp_b_q.pop_front();
        chk("b_word", 64'(bus_b.word_out), 64'(e_b[7:0]));
        chk("b_cnt", 64'(bus_b.word_cnt), 64'(e_b[79:64]));
      end
      held_b = bus_b.word_out;
      if (cap_lfsr) seen_q.push_back(bus_b.word_out);
    end
    prev_b = bus_b.ready;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] s;
    bit used[256];
    int distinct;

    s = 8'h01;
    for (int i = 0; i < 255; i++) begin
      lfsr_tab[i] = s;
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
    model_clear();

    reset = 1'b1; en = 1'b1; ready_in = 1'b0; mode = 2'd0; clear = 1'b0; ack = 1'b0;
    repeat (3) @(negedge rdclk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge rdclk);

    // Counter: first four words, then run through the 8-bit wrap.
    for (int i = 0; i < 4; i++) do_req(1'b1);
    chk("a_cnt_after_4", 64'(bus_a.word_cnt), 64'd4);
    for (int i = 0; i < 126; i++) do_req(1'b1);

    // Walking one across the full word and back to the top bit.
    clear_pulse();
    mode = 2'd1;
    for (int i = 0; i < 17; i++) do_req(1'b1);

    // LFSR: 255 distinct non-zero values, then back to the seed.
    clear_pulse();
    mode = 2'd2;
    cap_lfsr = 1'b1;
    for (int i = 0; i < 255; i++) do_req(1'b1);
    cap_lfsr = 1'b0;
    distinct = 0;
    foreach (seen_q[i]) begin
      if (seen_q[i] != 8'h00 && !used[seen_q[i]]) begin
        used[seen_q[i]] = 1'b1;
        distinct++;
      end
    end
    chk("lfsr_distinct", 64'(distinct), 64'd255);
    do_req(1'b1);
    chk("lfsr_wrap_b", 64'(bus_b.word_out), 64'h01);

    // Random modes, spacing and ack behaviour.
    clear_pulse();
    for (int i = 0; i < 40; i++) begin
      mode = 2'($urandom_range(0, 3));
      do_req($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) ack_pulse();
      repeat ($urandom_range(0, 3)) @(negedge rdclk);
      chk("rnd_b_overrun", 64'(bus_b.overrun), 64'(b_ov));
      chk("rnd_a_overrun", 64'(bus_a.overrun), 64'd0);
    end

    // Hold mode: held word, dropped request, ack, next word.
    clear_pulse();
    mode = 2'd0;
    do_req(1'b0);
    repeat (3) @(negedge rdclk);
    chk("hold_ready_high", 64'(bus_b.ready), 64'd1);
    do_req(1'b0);
    chk("hold_overrun", 64'(bus_b.overrun), 64'd1);
    chk("hold_cnt_unchanged", 64'(bus_b.word_cnt), 64'(m_cnt[1]));
    chk("hold_ready_still", 64'(bus_b.ready), 64'd1);
    ack_pulse();
    do_req(1'b1);

    // Enable low: request edge and ack ignored, state frozen.
    clear_pulse();
    mode = 2'd3;
    do_req(1'b0);
    ready_in = 1'b1;
    repeat (3) @(negedge rdclk);
    en = 1'b0;
    ready_in = 1'b0;
    ack = 1'b1;
    repeat (4) @(negedge rdclk);
    ack = 1'b0;
    chk("en0_b_ready_held", 64'(bus_b.ready), 64'd1);
    chk("en0_a_cnt", 64'(bus_a.word_cnt), 64'(m_cnt[0]));
    ready_in = 1'b1;
    @(negedge rdclk);
    en = 1'b1;
    repeat (4) @(negedge rdclk);
    chk("en1_a_cnt", 64'(bus_a.word_cnt), 64'(m_cnt[0]));
    chk("en1_b_overrun", 64'(bus_b.overrun), 64'd0);
    ack_pulse();
    do_req(1'b1);

    // Clear on the same edge as a request: request discarded.
    do_req(1'b0);
    do_req(1'b0);
    chk("pre_clr_overrun", 64'(bus_b.overrun), 64'd1);
    mode = 2'd0;
    ready_in = 1'b1;
    repeat (3) @(negedge rdclk);
    ready_in = 1'b0;
    clear = 1'b1;
    repeat (2) @(negedge rdclk);
    clear = 1'b0;
    model_clear();
    repeat (3) @(negedge rdclk);
    chk("clrtrig_b_overrun", 64'(bus_b.overrun), 64'd0);
    chk("clrtrig_b_ready", 64'(bus_b.ready), 64'd0);
    chk("clrtrig_a_cnt", 64'(bus_a.word_cnt), 64'd0);
    do_req(1'b1);
    chk("after_clr_a_word", 64'(bus_a.word_out), 64'h0001);

    // Reset while a held word is pending.
    do_req(1'b0);
    @(negedge rdclk);
    reset = 1'b1;
    @(negedge rdclk);
    chk_all_zero("midreset");
    reset = 1'b0;
    model_clear();
    repeat (2) @(negedge rdclk);

    chk("a_queue_empty", 64'(exp_a_q.size()), 64'd0);
    chk("b_queue_empty", 64'(exp_b_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
